// File: rtl/ofifo_drain_pkg.sv
// Shared widths and FSM state encoding for the output-FIFO drain block.
package ofifo_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned MAIN_BW = 73;
    localparam int unsigned AUX_BW  = 55;
    localparam int unsigned LANE_BW = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

endpackage

// File: rtl/ofifo_drain_unpack.sv
// Rebuilds one psum row from the main/aux store heads.
// Compressed rows carry COL signed 9-bit lanes in the main word only.
module psum_unpack
    import ofifo_pkg::*;
#(
    parameter int unsigned P_COL     = COL,
    parameter int unsigned P_PSUM_BW = PSUM_BW,
    parameter int unsigned P_MAIN_BW = MAIN_BW,
    parameter int unsigned P_AUX_BW  = AUX_BW,
    parameter int unsigned P_LANE_BW = LANE_BW
) (
    input  logic                           i_flag,
    input  logic [P_MAIN_BW-1:0]           i_main,
    input  logic [P_AUX_BW-1:0]            i_aux,
    output logic [P_COL*P_PSUM_BW-1:0]     o_row
);

    // Select raw concatenation or per-lane sign extension.
    always_comb begin
        o_row = '0;
        if (i_flag) begin
            for (int i = 0; i < int'(P_COL); i++) begin
                o_row[i*P_PSUM_BW +: P_PSUM_BW] =
                    {{(P_PSUM_BW-P_LANE_BW){i_main[i*P_LANE_BW+P_LANE_BW-1]}},
                     i_main[i*P_LANE_BW +: P_LANE_BW]};
            end
        end else begin
            o_row = {i_aux, i_main};
        end
    end

endmodule

// File: rtl/ofifo_drain.sv
// Drains a counted number of rows from flag/main/aux FWFT stores into a
// single registered output slot with valid/ready handshake.
module ofifo_drain
    import ofifo_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 num_rows,
    input  logic                       flag_data,
    input  logic                       flag_empty,
    input  logic [MAIN_BW-1:0]         main_data,
    input  logic                       main_empty,
    input  logic [AUX_BW-1:0]          aux_data,
    input  logic                       aux_empty,
    output logic                       rd_main,
    output logic                       rd_aux,
    output logic [COL*PSUM_BW-1:0]     out,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned ROW_BW = COL * PSUM_BW;
    localparam int unsigned CNT_BW = 9;

    state_e              r_state;
    logic [CNT_BW-1:0]   r_cnt;
    logic [ROW_BW-1:0]   r_out;
    logic                r_valid;
    logic                r_done;

    logic                w_head_avail;
    logic                w_pop;
    logic [ROW_BW-1:0]   w_row;

    psum_unpack u_unpack (
        .i_flag (flag_data),
        .i_main (main_data),
        .i_aux  (aux_data),
        .o_row  (w_row)
    );

    // Pop when a full row is at the heads and the output slot is free or freeing.
    assign w_head_avail = !flag_empty && !main_empty && (flag_data || !aux_empty);
    assign w_pop        = !reset && (r_state == ST_RUN) && w_head_avail
                          && (!r_valid || i_ready);

    assign rd_main = w_pop;
    assign rd_aux  = w_pop && !flag_data;
    assign out     = r_out;
    assign o_valid = r_valid;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

    // Drain FSM, row counter and output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_pop) begin
                r_out   <= w_row;
                r_valid <= 1'b1;
                r_cnt   <= r_cnt - CNT_BW'(1);
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= (num_rows == 8'd0) ? CNT_BW'(256) : CNT_BW'(num_rows);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pop && (r_cnt == CNT_BW'(1))) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_valid && i_ready) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_drain.sv
// Randomized bench for ofifo_drain: the stores are modelled as queues and the
// expected output stream/handshake is derived from a row-count level model.
module tb_ofifo_drain;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [7:0]     num_rows = '0;
    logic           flag_data = 1'b0;
    logic           flag_empty = 1'b1;
    logic [72:0]    main_data = '0;
    logic           main_empty = 1'b1;
    logic [54:0]    aux_data = '0;
    logic           aux_empty = 1'b1;
    logic           rd_main;
    logic           rd_aux;
    logic [127:0]   out;
    logic           o_valid;
    logic           i_ready = 1'b0;
    logic           busy;
    logic           done;

    ofifo_drain dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_rows   (num_rows),
        .flag_data  (flag_data),
        .flag_empty (flag_empty),
        .main_data  (main_data),
        .main_empty (main_empty),
        .aux_data   (aux_data),
        .aux_empty  (aux_empty),
        .rd_main    (rd_main),
        .rd_aux     (rd_aux),
        .out        (out),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // External stores and expected row stream.
    bit           fq[$];
    logic [72:0]  mq[$];
    logic [54:0]  aq[$];
    logic [127:0] exp_q[$];

    // Row-count level model of the drain.
    bit           m_active = 0;
    int           m_left   = 0;
    bit           m_valid  = 0;
    logic [127:0] m_out    = '0;
    bit           m_done   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] ref_row(input bit f, input logic [72:0] m, input logic [54:0] a);
        logic [127:0] r;
        int v;
        r = '0;
        if (!f) begin
            r = {a, m};
        end else begin
            for (int i = 0; i < 8; i++) begin
                v = int'(m[9*i +: 9]);
                if (v >= 256) v = v - 512;
                r[16*i +: 16] = 16'(v);
            end
        end
        return r;
    endfunction

    task automatic push_row(input bit f, input logic [72:0] m, input logic [54:0] a);
        fq.push_back(f);
        mq.push_back(m);
        if (!f) aq.push_back(a);
        exp_q.push_back(ref_row(f, m, a));
    endtask

    task automatic push_rand(input int n);
        for (int k = 0; k < n; k++)
            push_row(1'($urandom_range(0, 1)),
                     73'({$urandom, $urandom, $urandom}),
                     55'({$urandom, $urandom}));
    endtask

    // One clock: drive at negedge, check DUT against model, advance model.
    task automatic tick(input bit st, input logic [7:0] nr, input bit rdy,
                        input bit sf, input bit sm, input bit sa);
        bit head, pop, accept, was_active, flush_done, fd;
        @(negedge clk);
        start      = st;
        num_rows   = nr;
        i_ready    = rdy;
        flag_empty = sf || (fq.size() == 0);
        flag_data  = (fq.size() != 0) ? fq[0] : 1'b0;
        main_empty = sm || (mq.size() == 0);
        main_data  = (mq.size() != 0) ? mq[0] : '0;
        aux_empty  = sa || (aq.size() == 0);
        aux_data   = (aq.size() != 0) ? aq[0] : '0;
        #1;
        fd     = flag_data;
        head   = !flag_empty && !main_empty && (fd || !aux_empty);
        pop    = m_active && (m_left > 0) && head && (!m_valid || rdy);
        accept = m_valid && rdy;

        check("rd_main", rd_main, pop);
        check("rd_aux", rd_aux, pop && !fd);
        check("o_valid", o_valid, m_valid);
        check("out", out, m_out);
        check("busy", busy, m_active);
        check("done", done, m_done);

        was_active = m_active;
        flush_done = m_active && (m_left == 0) && accept;
        if (pop) begin
            void'(fq.pop_front());
            void'(mq.pop_front());
            if (!fd) void'(aq.pop_front());
            if (exp_q.size() != 0) m_out = exp_q.pop_front();
            m_valid = 1;
            m_left--;
        end else if (accept) begin
            m_valid = 0;
        end
        m_done = flush_done;
        if (flush_done) m_active = 0;
        if (!was_active && st) begin
            m_active = 1;
            m_left   = (nr == 8'd0) ? 256 : int'(nr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; i_ready = 1'b0;
        #1;
        check("rst_rd_main_pre", rd_main, 1'b0);
        check("rst_rd_aux_pre", rd_aux, 1'b0);
        fq.delete(); mq.delete(); aq.delete(); exp_q.delete();
        m_active = 0; m_left = 0; m_valid = 0; m_out = '0; m_done = 0;
        @(negedge clk);
        flag_empty = 1'b1; main_empty = 1'b1; aux_empty = 1'b1;
        #1;
        check("rst_out", out, '0);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_main", rd_main, 1'b0);
        check("rst_rd_aux", rd_aux, 1'b0);
        reset = 1'b0;
    endtask

    // Run one drain. Windows are cycle indices (-1 disables). abort_after>0
    // resets the DUT once that many rows have been popped.
    task automatic drain(input logic [7:0] nr, input int rows_rand, input int rdy_pct,
                         input int stall_pct, input int rdy_lo, input int rdy_hi,
                         input int stl_lo, input int stl_hi, input int abort_after,
                         input int budget);
        int cyc, pushed, req;
        bit rdy, sm, sf, sa, spam;
        logic [7:0] nr_drv;
        cyc = 0; pushed = 0;
        req = (nr == 8'd0) ? 256 : int'(nr);
        tick(1'b1, nr, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc++;
        while (m_active && cyc < budget) begin
            if (abort_after > 0 && (req - m_left) >= abort_after) begin
                do_reset();
                return;
            end
            if (pushed < rows_rand && $urandom_range(0, 99) < 75) begin
                push_rand(1);
                pushed++;
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            if (cyc >= rdy_lo && cyc <= rdy_hi) rdy = 1'b0;
            sm = ($urandom_range(0, 99) < stall_pct);
            if (cyc >= stl_lo && cyc <= stl_hi) sm = 1'b1;
            sf = ($urandom_range(0, 99) < stall_pct);
            sa = ($urandom_range(0, 99) < stall_pct);
            spam = ($urandom_range(0, 3) == 0);
            nr_drv = spam ? 8'($urandom_range(0, 255)) : nr;
            tick(spam, nr_drv, rdy, sf, sm, sa);
            cyc++;
        end
        if (m_active) check("drain_timeout", 1'b1, 1'b0);
        tick(1'b0, nr, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rows_left", 128'(exp_q.size()), 128'(0));
    endtask

    logic [72:0] m_cmp;
    logic [72:0] m_unc;

    initial begin
        do_reset();

        // Single uncompressed row
        m_unc = 73'h0_0001_0002_0003_0004_0005;
        push_row(1'b0, m_unc, 55'h12_3456);
        drain(8'd1, 0, 100, 0, -1, -1, -1, -1, 0, 50);

        // Single compressed row; top main bit must be ignored
        m_cmp = {1'b1, {7{9'h1FF}}, 9'h005};
        push_row(1'b1, m_cmp, 55'h0);
        drain(8'd1, 0, 100, 0, -1, -1, -1, -1, 0, 50);

        // Backpressure window on a 4-row drain
        push_rand(4);
        drain(8'd4, 0, 100, 0, 2, 5, -1, -1, 0, 100);

        // Main store stall mid-stream, then full throughput
        push_rand(8);
        drain(8'd8, 0, 100, 0, -1, -1, 3, 5, 0, 100);

        // num_rows=0 means 256, with random ready/stalls and start spam
        drain(8'd0, 256, 70, 10, -1, -1, -1, -1, 0, 4000);

        // Reset after 3 of 10 rows, then a clean drain
        push_rand(10);
        drain(8'd10, 0, 80, 0, -1, -1, -1, -1, 3, 200);
        push_rand(5);
        drain(8'd5, 0, 100, 0, -1, -1, -1, -1, 0, 100);

        // Random drains
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 20);
            drain(8'(n), n, $urandom_range(40, 100), $urandom_range(0, 30),
                  -1, -1, -1, -1, 0, 1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofifo_drain.md
OFIFO_DRAIN -- requirements
Module: ofifo_drain

Interface
REQ-001 Parameters, one per line: COL, 8, psum lanes per row; PSUM_BW, 16, bits per psum; MAIN_BW, 73, main-store word width; AUX_BW, 55, aux-store word width.
REQ-002 Clock is clk, reset is reset: one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  begin draining num_rows rows.
- num_rows  in  8  row count (0 means 256).
- flag_data  in  1  head of flag store; 1 = row compressed.
- flag_empty  in  1  flag store empty.
- main_data  in  MAIN_BW  head of main store (first-word-fall-through).
- main_empty  in  1  main store empty.
- aux_data  in  AUX_BW  head of aux store.
- aux_empty  in  1  aux store empty.
- rd_main  out  1  pop flag and main stores this edge.
- rd_aux  out  1  pop aux store this edge.
- out  out  COL*PSUM_BW  reconstructed psum row.
- o_valid  out  1  out holds a row.
- i_ready  in  1  consumer accepts out.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-004 States: IDLE, RUN, FLUSH. IDLE->RUN on start; RUN->FLUSH once the last row has been popped; FLUSH->IDLE when the last row is accepted (o_valid && i_ready), with done=1 for that one cycle.
REQ-005 start SHALL be ignored outside IDLE; in IDLE it loads the remaining-row counter from num_rows (0 loads 256).
REQ-006 Head-available condition: !flag_empty && !main_empty && (flag_data || !aux_empty).
- Pop: in RUN, when head-available && (!o_valid || i_ready).
REQ-007 On a pop: rd_main=1; rd_aux=!flag_data; the row is registered into out with o_valid=1 on the next edge (1-cycle latency); the remaining-row counter decrements.
REQ-008 rd_main and rd_aux SHALL be 0 in IDLE and FLUSH, and whenever no pop occurs.
REQ-009 Sustained throughput is one row per cycle while stores are non-empty and i_ready=1; a simultaneous accept and pop replaces out without an o_valid bubble.
REQ-010 Hold: when o_valid=1 && i_ready=0, out and o_valid SHALL stay stable and no pop occurs.
REQ-011 o_valid clears on accept when no pop occurs in the same cycle.
REQ-012 Uncompressed row (flag_data=0): out = {aux_data, main_data}, with aux_data in bits 127:73.
REQ-013 Compressed row (flag_data=1): lane i (i=0..7) = main_data[9i+8:9i], sign-extended to 16 bits, placed at out[16i+15:16i]; main_data[72] is ignored.
REQ-014 Empty stores stall RUN indefinitely; no pop, no error, and out is unchanged.
REQ-015 busy=1 in RUN and FLUSH, 0 in IDLE.

Reset
REQ-016 While reset=1 on an edge: state=IDLE, counter=0, out=0, o_valid=0, done=0, busy=0, rd_main=0, rd_aux=0. This includes reset mid-drain; popped but unaccepted data is discarded.

Structure
REQ-017 Package ofifo_pkg SHALL hold COL, PSUM_BW, MAIN_BW, AUX_BW, compressed lane width 9, and the state encoding (IDLE=2'b00, RUN=2'b01, FLUSH=2'b10).
REQ-018 One combinational sub-module, psum_unpack (flag, main, aux -> row), SHALL implement REQ-012 and REQ-013.

Verification
REQ-019 Uncompressed row: num_rows=1, flag=0, main=73'h0_0001_0002_0003_0004_0005, aux=55'h12_3456 -> rd_main=rd_aux=1 for one cycle; next cycle out={aux,main}, o_valid=1; done pulses on accept.
REQ-020 Compressed row: flag=1, all lanes 9'h1FF, lane0 9'h005 -> out = lane0 16'h0005, lanes 1-7 16'hFFFF; rd_aux=0.
REQ-021 Backpressure: 4 rows, i_ready low for cycles 2-5 -> out stable and no pops while low; all 4 rows delivered in order; done once.
REQ-022 Stall/throughput: 8 rows, main_empty=1 for 3 cycles mid-stream, then continuous with i_ready=1 -> no pops during the stall, then one row per cycle.
REQ-023 Boundary: num_rows=0 -> 256 rows drained; start asserted while busy is ignored.
REQ-024 Reset mid-drain at row 3 of 10 -> all outputs 0 on the next cycle; a new start drains cleanly.
